karatsuba_seq_ctrl: RTL and testbench

Sequencer that computes a 12x12 unsigned product with the Karatsuba decomposition, time-sharing one external combinational 6x6 multiplier over three cycles. It sits between a valid/ready operand source and a valid/ready result sink. It owns the multiplier's operand inputs and does the pre-add, the post-correction and the final recombination.

---
 rtl/karatsuba_pkg.sv | 19 +
 rtl/karatsuba_mid_fix.sv | 34 +++
 rtl/karatsuba_seq_ctrl.sv | 111 +++++++++++
 tb/tb_karatsuba_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared widths and FSM state type for the sequential 12x12 Karatsuba multiplier.
package karatsuba_pkg;

  localparam int unsigned HALF_W = 6;
  localparam int unsigned FULL_W = 12;
  localparam int unsigned SUM_W  = 7;
  localparam int unsigned MID_W  = 14;
  localparam int unsigned Z1_W   = 13;
  localparam int unsigned PROD_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    MUL_LO,
    MUL_HI,
    MUL_MID,
    DONE
  } state_e;

endpackage

// File: rtl/karatsuba_mid_fix.sv
// Middle Karatsuba term: rebuilds sa*sb from the 6x6 product of the low sum bits,
// then removes z2 and z0.
module karatsuba_mid_fix
  import karatsuba_pkg::*;
(
  input  logic [FULL_W-1:0] mul_c_i,
  input  logic [SUM_W-1:0]  sa_i,
  input  logic [SUM_W-1:0]  sb_i,
  input  logic [FULL_W-1:0] z0_i,
  input  logic [FULL_W-1:0] z2_i,
  output logic [Z1_W-1:0]   z1_o
);

  logic [MID_W-1:0] w_corr_a;
  logic [MID_W-1:0] w_corr_b;
  logic [MID_W-1:0] w_corr_ab;
  logic [MID_W-1:0] w_m;
  logic [MID_W-1:0] w_diff;

  // The multiplier only sees sa[5:0]*sb[5:0]; the carry bits of the sums add the cross terms back.
  always_comb begin
    w_corr_a  = sa_i[SUM_W-1] ? {2'b00, sb_i[HALF_W-1:0], 6'b000000} : '0;
    w_corr_b  = sb_i[SUM_W-1] ? {2'b00, sa_i[HALF_W-1:0], 6'b000000} : '0;
    w_corr_ab = (sa_i[SUM_W-1] & sb_i[SUM_W-1]) ? MID_W'(4096) : '0;
    w_m       = {2'b00, mul_c_i} + w_corr_a + w_corr_b + w_corr_ab;
    w_diff    = w_m - {2'b00, z2_i} - {2'b00, z0_i};
    z1_o      = w_diff[Z1_W-1:0];
  end

  // z1 never exceeds 7938, so the top difference bit is always zero.
  logic w_unused;
  assign w_unused = w_diff[MID_W-1];

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequencer for a 12x12 unsigned Karatsuba product sharing one external 6x6
// combinational multiplier over three cycles, with valid/ready on both sides.
module karatsuba_seq_ctrl
  import karatsuba_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [FULL_W-1:0] a_i,
  input  logic [FULL_W-1:0] b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PROD_W-1:0] p_o,
  output logic [HALF_W-1:0] mul_a_o,
  output logic [HALF_W-1:0] mul_b_o,
  input  logic [FULL_W-1:0] mul_c_i
);

  state_e              r_state;
  state_e              w_state_d;
  logic [HALF_W-1:0]   r_a0, r_a1, r_b0, r_b1;
  logic [SUM_W-1:0]    r_sa, r_sb;
  logic [FULL_W-1:0]   r_z0, r_z2;
  logic [PROD_W-1:0]   r_p;
  logic [Z1_W-1:0]     w_z1;
  logic [PROD_W-1:0]   w_p;
  logic                w_accept;

  karatsuba_mid_fix u_mid_fix (
    .mul_c_i (mul_c_i),
    .sa_i    (r_sa),
    .sb_i    (r_sb),
    .z0_i    (r_z0),
    .z2_i    (r_z2),
    .z1_o    (w_z1)
  );

  assign w_accept = (r_state == IDLE) & in_valid_i;
  assign w_p      = (PROD_W'(r_z2) << FULL_W) + (PROD_W'(w_z1) << HALF_W) + PROD_W'(r_z0);
  assign p_o      = r_p;

  always_comb begin
    w_state_d   = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    mul_a_o     = '0;
    mul_b_o     = '0;
    unique case (r_state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) w_state_d = MUL_LO;
      end
      MUL_LO: begin
        mul_a_o   = r_a0;
        mul_b_o   = r_b0;
        w_state_d = MUL_HI;
      end
      MUL_HI: begin
        mul_a_o   = r_a1;
        mul_b_o   = r_b1;
        w_state_d = MUL_MID;
      end
      MUL_MID: begin
        mul_a_o   = r_sa[HALF_W-1:0];
        mul_b_o   = r_sb[HALF_W-1:0];
        w_state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a0 <= '0;
      r_a1 <= '0;
      r_b0 <= '0;
      r_b1 <= '0;
      r_sa <= '0;
      r_sb <= '0;
      r_z0 <= '0;
      r_z2 <= '0;
      r_p  <= '0;
    end else begin
      if (w_accept) begin
        r_a0 <= a_i[HALF_W-1:0];
        r_a1 <= a_i[FULL_W-1:HALF_W];
        r_b0 <= b_i[HALF_W-1:0];
        r_b1 <= b_i[FULL_W-1:HALF_W];
        r_sa <= {1'b0, a_i[FULL_W-1:HALF_W]} + {1'b0, a_i[HALF_W-1:0]};
        r_sb <= {1'b0, b_i[FULL_W-1:HALF_W]} + {1'b0, b_i[HALF_W-1:0]};
      end
      if (r_state == MUL_LO)  r_z0 <= mul_c_i;
      if (r_state == MUL_HI)  r_z2 <= mul_c_i;
      if (r_state == MUL_MID) r_p  <= w_p;
    end
  end

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Bench for karatsuba_seq_ctrl: behavioural model of the handshake/operand schedule with a
// per-cycle compare, directed cases with literal products, and 10k random operand pairs.
module tb_karatsuba_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] a = '0;
  logic [11:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] p;
  logic [5:0]  ma;
  logic [5:0]  mb;
  logic [11:0] mc;

  // External 6x6 combinational multiplier.
  assign mc = {6'b0, ma} * {6'b0, mb};

  always #5 clk = ~clk;

  karatsuba_seq_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .p_o         (p),
    .mul_a_o     (ma),
    .mul_b_o     (mb),
    .mul_c_i     (mc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: an accepted pair schedules three multiplier operand pairs, then the
  // product A*B is presented until a handshake.
  int          m_left;
  bit          m_done;
  logic [23:0] m_p;
  logic [23:0] m_pend;
  logic [5:0]  m_pa[3];
  logic [5:0]  m_pb[3];
  int          m_acc_cnt;
  longint      m_acc_cyc;
  longint      m_prev_acc_cyc;
  longint      cyc = 0;
  int          hs_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left    <= 0;
      m_done    <= 1'b0;
      m_p       <= '0;
      m_pend    <= '0;
      m_acc_cnt <= 0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_p    <= m_pend;
      end
    end else if (in_valid) begin
      m_left         <= 3;
      m_pa[0]        <= a[5:0];
      m_pb[0]        <= b[5:0];
      m_pa[1]        <= a[11:6];
      m_pb[1]        <= b[11:6];
      m_pa[2]        <= 6'(a[11:6] + a[5:0]);
      m_pb[2]        <= 6'(b[11:6] + b[5:0]);
      m_pend         <= {12'b0, a} * {12'b0, b};
      m_acc_cnt      <= m_acc_cnt + 1;
      m_prev_acc_cyc <= m_acc_cyc;
      m_acc_cyc      <= cyc;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(!m_done && m_left == 0));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      chk("mul_a", 32'(ma), (m_left != 0) ? 32'(m_pa[3-m_left]) : 32'd0);
      chk("mul_b", 32'(mb), (m_left != 0) ? 32'(m_pb[3-m_left]) : 32'd0);
      chk("p_o", 32'(p), 32'(m_p));
    end
  end

  task automatic wait_accept();
    int k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (in_ready) break;
      k++;
    end
    if (k == 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [11:0] ta, input logic [11:0] tb_v, input int stall,
                        output logic [23:0] res, output int lat);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    out_ready = 1'b0;
    wait_accept();
    // Operands and valid may wander once accepted.
    in_valid = 1'($urandom_range(0, 1));
    a = 12'($urandom);
    b = 12'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
    res = p;
    in_valid = 1'b0;
    repeat (stall) @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [23:0] res;
    int          lat;
    int          hs0;
    int          acc0;
    int          k;

    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    chk("rst_mul", {26'd0, ma}, 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Both pre-sums overflow (126 each).
    run_op(12'hFFF, 12'hFFF, 0, res, lat);
    chk("fff_p", 32'(res), 32'h00FFE001);
    chk("fff_latency", 32'(lat), 32'd3);

    // Reset while in MUL_HI: everything returns to reset values without a clock edge.
    a = 12'hABC;
    b = 12'h123;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_mul_a", 32'(ma), 32'(12'hABC >> 6));
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_p", 32'(p), 32'd0);
    chk("midrst_mul_a", 32'(ma), 32'd0);
    chk("midrst_mul_b", 32'(mb), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Same operation again, held in DONE for five cycles.
    hs0 = hs_cnt;
    run_op(12'hABC, 12'h123, 5, res, lat);
    chk("abc_p", 32'(res), 32'h000C33B4);
    chk("abc_p_held", 32'(p), 32'h000C33B4);
    chk("abc_one_handshake", 32'(hs_cnt - hs0), 32'd1);

    run_op(12'h040, 12'h040, 0, res, lat);
    chk("x040_p", 32'(res), 32'h00001000);
    run_op(12'h000, 12'hFFF, 1, res, lat);
    chk("zero_p", 32'(res), 32'h00000000);

    // Back-to-back with both valids held high.
    acc0 = m_acc_cnt;
    a = 12'h001;
    b = 12'h001;
    in_valid = 1'b1;
    out_ready = 1'b1;
    k = 0;
    while (m_acc_cnt == acc0 && k < 50) begin @(posedge clk); #1; k++; end
    a = 12'h800;
    b = 12'h002;
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    chk("b2b_first_p", 32'(p), 32'h00000001);
    k = 0;
    while (m_acc_cnt < acc0 + 2 && k < 50) begin @(posedge clk); #1; k++; end
    in_valid = 1'b0;
    // An accept cycle, LO, HI, MID and the DONE handshake put accepts five edges apart.
    chk("b2b_accept_spacing", 32'(m_acc_cyc - m_prev_acc_cyc), 32'd5);
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    chk("b2b_second_p", 32'(p), 32'h00001000);
    @(posedge clk);
    #2;
    out_ready = 1'b0;

    for (int i = 0; i < 10000; i++) begin
      logic [11:0] ra;
      logic [11:0] rb;
      int          st;
      ra = 12'($urandom);
      rb = 12'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a = 12'($urandom);
        b = 12'($urandom);
        @(posedge clk);
        #2;
      end
      st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(ra, rb, st, res, lat);
      chk("rand_p", 32'(res), 32'({12'b0, ra} * {12'b0, rb}));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
